// File: rtl/zjh_vote_pkg.sv
// Shared types and helpers for the N-voter voting controller.
// The ZJH_VOTE_VETO_EN build option is handled in zjh_vote_ctrl.
package zjh_vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold any value 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/zjh_popcnt.sv
// Combinational population count of a W-bit vector.
module zjh_popcnt
    import zjh_vote_pkg::*;
#(
    parameter  int W  = 5,
    localparam int CW = cnt_width(W)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/zjh_vote_ctrl.sv
// N-voter voting controller: opens a session, tallies first votes, closes on command,
// full turnout or timeout, and registers a threshold decision. Optional veto: ZJH_VOTE_VETO_EN.
module zjh_vote_ctrl
    import zjh_vote_pkg::*;
#(
    parameter  int N_VOTER = 5,
    parameter  int THRESH  = (N_VOTER / 2) + 1,
    parameter  int TIMEOUT = 0,
    localparam int CW      = cnt_width(N_VOTER)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               close,
    input  logic [N_VOTER-1:0] vote_vld,
    input  logic [N_VOTER-1:0] vote_yes,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CW-1:0]      yes_cnt,
    output logic [CW-1:0]      no_cnt,
    output logic [N_VOTER-1:0] voted
`ifdef ZJH_VOTE_VETO_EN
    ,
    input  logic               veto,
    output logic               vetoed
`endif
);

    localparam int                 TW         = cnt_width(TIMEOUT);
    localparam logic [TW-1:0]      TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]      THRESH_C   = CW'(THRESH);
    localparam logic [N_VOTER-1:0] ALL_VOTED  = '1;

    generate
        if (N_VOTER < 2 || N_VOTER > 16) begin : g_bad_n_voter
            $error("zjh_vote_ctrl: N_VOTER must be within 2..16");
        end
        if (THRESH < 1 || THRESH > N_VOTER) begin : g_bad_thresh
            $error("zjh_vote_ctrl: THRESH must be within 1..N_VOTER");
        end
    endgenerate

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       timer;
    logic                in_open;
    logic                open_now;
    logic                close_now;
    logic                all_voted;
    logic                timeout_hit;
    logic                veto_final;
    logic [N_VOTER-1:0]  accept;
    logic [N_VOTER-1:0]  yes_mask;
    logic [N_VOTER-1:0]  no_mask;
    logic [CW-1:0]       yes_add;
    logic [CW-1:0]       no_add;
    logic [CW-1:0]       yes_total;
    logic [CW-1:0]       no_total;

    // Strobe semantics: start is a level sampled on each rising edge and acts only in IDLE/DONE;
    // close acts only in OPEN; vote_vld[i] offers one vote per edge with its value on vote_yes[i]
    // and is taken only while OPEN and voter i has not voted yet (no back-pressure, first vote wins).
    assign in_open   = (state == ST_OPEN);
    assign open_now  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign accept    = in_open ? (vote_vld & ~voted) : '0;
    assign yes_mask  = accept & vote_yes;
    assign no_mask   = accept & ~vote_yes;

    zjh_popcnt #(.W(N_VOTER)) u_pop_yes (
        .bits (yes_mask),
        .cnt  (yes_add)
    );

    zjh_popcnt #(.W(N_VOTER)) u_pop_no (
        .bits (no_mask),
        .cnt  (no_add)
    );

    // Tallies cannot exceed N_VOTER, so CW bits always suffice.
    assign yes_total   = yes_cnt + yes_add;
    assign no_total    = no_cnt + no_add;
    assign all_voted   = ((voted | accept) == ALL_VOTED);
    assign timeout_hit = (TIMEOUT > 0) && (timer == TIMER_LAST);
    assign close_now   = in_open && (close || all_voted || timeout_hit);
    assign busy        = in_open;

`ifdef ZJH_VOTE_VETO_EN
    logic veto_now;

    assign veto_now   = in_open && veto;
    assign veto_final = vetoed || veto_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vetoed <= 1'b0;
        end else if (open_now) begin
            vetoed <= 1'b0;
        end else if (veto_now) begin
            vetoed <= 1'b1;
        end
    end
`else
    assign veto_final = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_OPEN;
            ST_OPEN: if (close_now) state_nxt = ST_DONE;
            ST_DONE: if (start)     state_nxt = ST_OPEN;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Session datapath: cleared on entry to OPEN, frozen outside OPEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            yes_cnt <= '0;
            no_cnt  <= '0;
            voted   <= '0;
            timer   <= '0;
        end else begin
            done <= close_now;
            if (open_now) begin
                pass    <= 1'b0;
                yes_cnt <= '0;
                no_cnt  <= '0;
                voted   <= '0;
                timer   <= '0;
            end else if (in_open) begin
                yes_cnt <= yes_total;
                no_cnt  <= no_total;
                voted   <= voted | accept;
                timer   <= timer + TW'(1);
                if (close_now) begin
                    pass <= (yes_total >= THRESH_C) && !veto_final;
                end
            end
        end
    end

endmodule

// File: tb/tb_zjh_vote_ctrl.sv
// Scoreboard bench for zjh_vote_ctrl (N_VOTER=5, THRESH=3, TIMEOUT=16); optional ZJH_VOTE_VETO_EN.
module tb_zjh_vote_ctrl;

    localparam int N   = 5;
    localparam int THR = 3;
    localparam int TMO = 16;
    localparam int CW  = 3;
`ifdef ZJH_VOTE_VETO_EN
    localparam int RW  = 2 * CW + N + 2;
`else
    localparam int RW  = 2 * CW + N + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          close = 1'b0;
    logic [N-1:0]  vote_vld = '0;
    logic [N-1:0]  vote_yes = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] yes_cnt;
    logic [CW-1:0] no_cnt;
    logic [N-1:0]  voted;
`ifdef ZJH_VOTE_VETO_EN
    logic          veto = 1'b0;
    logic          vetoed;
`endif

    zjh_vote_ctrl #(.N_VOTER(N), .THRESH(THR), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .close    (close),
        .vote_vld (vote_vld),
        .vote_yes (vote_yes),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .yes_cnt  (yes_cnt),
        .no_cnt   (no_cnt),
        .voted    (voted)
`ifdef ZJH_VOTE_VETO_EN
        ,
        .veto     (veto),
        .vetoed   (vetoed)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [RW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [RW-1:0] hold_val = '0;
    logic          hold_valid = 1'b0;

    // Session plan: per-cycle stimulus for OPEN cycles 0..TMO-1.
    logic [N-1:0]  p_vld[TMO];
    logic [N-1:0]  p_yes[TMO];
    logic          p_close[TMO];
    logic          p_start[TMO];
    logic          p_veto[TMO];

    function automatic logic [RW-1:0] observed();
`ifdef ZJH_VOTE_VETO_EN
        return {pass, yes_cnt, no_cnt, voted, vetoed};
`else
        return {pass, yes_cnt, no_cnt, voted};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] rand_mask(input int odds);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, odds - 1) == 0);
        return m;
    endfunction

    task automatic clear_plan();
        for (int c = 0; c < TMO; c++) begin
            p_vld[c] = '0; p_yes[c] = '0; p_close[c] = 1'b0; p_start[c] = 1'b0; p_veto[c] = 1'b0;
        end
    endtask

    task automatic random_plan();
        for (int c = 0; c < TMO; c++) begin
            p_vld[c]   = rand_mask(4);
            p_yes[c]   = N'($urandom);
            p_close[c] = ($urandom_range(0, 11) == 0);
            p_start[c] = ($urandom_range(0, 3) == 0);
            p_veto[c]  = ($urandom_range(0, 24) == 0);
        end
    endtask

    // Reference: walk the plan, first vote per voter wins, session ends on close,
    // full turnout or the last allowed cycle, whichever comes first.
    task automatic model(output int e, output logic [RW-1:0] res);
        logic [N-1:0] vm;
        int           y;
        int           n;
        logic         vt;
        logic         ps;
        vm = '0; y = 0; n = 0; vt = 1'b0; e = TMO - 1;
        for (int c = 0; c < TMO; c++) begin
            for (int i = 0; i < N; i++) begin
                if (p_vld[c][i] && !vm[i]) begin
                    vm[i] = 1'b1;
                    if (p_yes[c][i]) y++;
                    else n++;
                end
            end
`ifdef ZJH_VOTE_VETO_EN
            if (p_veto[c]) vt = 1'b1;
`endif
            if (p_close[c] || (y + n == N) || c == TMO - 1) begin
                e = c;
                break;
            end
        end
        ps = (y >= THR) && !vt;
`ifdef ZJH_VOTE_VETO_EN
        res = {ps, CW'(y), CW'(n), vm, vt};
`else
        res = {ps, CW'(y), CW'(n), vm};
`endif
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        start = 1'b0; close = 1'b0; vote_vld = '0; vote_yes = '0;
`ifdef ZJH_VOTE_VETO_EN
        veto = 1'b0;
`endif
    endtask

    task automatic drive_junk(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            vote_vld = rand_mask(2);
            vote_yes = N'($urandom);
            close    = $urandom_range(0, 1) == 1;
            start    = 1'b0;
`ifdef ZJH_VOTE_VETO_EN
            veto     = $urandom_range(0, 1) == 1;
`endif
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic run_session();
        int            e;
        logic [RW-1:0] r;
        model(e, r);
        exp_q.push_back(r);
        exp_cyc_q.push_back(cyc + e + 2);
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= e; c++) begin
            check("busy_open", {busy, done}, 2'b10);
            vote_vld = p_vld[c];
            vote_yes = p_yes[c];
            close    = p_close[c];
            start    = p_start[c];
`ifdef ZJH_VOTE_VETO_EN
            veto     = p_veto[c];
`endif
            @(negedge clk);
        end
        drive_junk(2);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [RW-1:0] r;
        int            ec;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_val   = '0;
                hold_valid = 1'b1;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL done_unexpected: got done=1 expected no decision (cycle %0d)", cyc);
                end else begin
                    r  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("result", observed(), r);
                    check("done_cycle", cyc, ec);
                    check("busy_at_done", busy, 1'b0);
                    hold_val   = r;
                    hold_valid = 1'b1;
                end
            end else if (busy) begin
                hold_valid = 1'b0;
            end else if (hold_valid) begin
                check("hold", observed(), hold_val);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", observed(), '0);
        check("reset_flags", {busy, done}, 2'b00);
        rst_n = 1'b1;
        drive_junk(3);

        // Three yes in one cycle, two no the next: closes on full turnout.
        clear_plan();
        p_vld[0] = 5'b00111; p_yes[0] = 5'b00111;
        p_vld[1] = 5'b11000; p_yes[1] = 5'b00000;
        run_session();

        // Repeat votes from voter 0, including a changed value, then close.
        clear_plan();
        p_vld[0] = 5'b00001; p_yes[0] = 5'b00001;
        p_vld[1] = 5'b00001; p_yes[1] = 5'b00001;
        p_vld[2] = 5'b00001; p_yes[2] = 5'b00000;
        p_close[3] = 1'b1;
        run_session();

        // Two yes votes then silence: runs to the timeout.
        clear_plan();
        p_vld[0] = 5'b00011; p_yes[0] = 5'b00011;
        run_session();

        // Votes arriving in the closing cycle are counted.
        clear_plan();
        p_vld[0] = 5'b11100; p_yes[0] = 5'b11100; p_close[0] = 1'b1;
        run_session();

        // Asynchronous reset in the middle of a session.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vote_vld = 5'b00011; vote_yes = 5'b00011;
        @(negedge clk);
        check("pre_reset_yes", yes_cnt, 3'd2);
        vote_vld = '0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", observed(), '0);
        check("async_reset_flags", {busy, done}, 2'b00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive_junk(3);

`ifdef ZJH_VOTE_VETO_EN
        // Unanimous yes with a veto pulse, then a clean session clears the veto.
        clear_plan();
        p_veto[0] = 1'b1;
        p_vld[1] = 5'b11111; p_yes[1] = 5'b11111;
        run_session();
        clear_plan();
        p_vld[0] = 5'b00111; p_yes[0] = 5'b00111; p_close[1] = 1'b1;
        run_session();
`endif

        for (int s = 0; s < 40; s++) begin
            random_plan();
            run_session();
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
